// File: rtl/mux_nx1_rr.sv
// ---------------------------------------------------------------------------
// mux_nx1_rr
//
// N-channel, W-bit multiplexer with a one-entry registered output stage.
// Each producer channel offers a word with valid/ready. One channel is granted
// per transfer, either by the external fixed select or by round-robin search
// starting after the last served channel. The chosen word is held in the
// output register until the consumer takes it.
//
// Parameters
//   WIDTH  data width per channel (1..64)
//   CH     number of input channels (power of two, 2..16)
//   SELW   channel index width, derived from CH (do not override)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    CH*WIDTH packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel data-present flags
//   in_ready   per-channel accept, combinational, one-hot or zero
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel used in fixed mode
//   out_data   registered selected word
//   out_ch     index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word this cycle
// ---------------------------------------------------------------------------
module mux_nx1_rr #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   in_data,
    input  logic [CH-1:0]         in_valid,
    output logic [CH-1:0]         in_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Output-stage and arbitration state
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_ch_r;
    logic             out_valid_r;
    logic [SELW-1:0]  ptr_r;

    // Combinational arbitration results
    logic             load_s;
    logic             rr_found_s;
    logic [SELW-1:0]  rr_idx_s;
    logic             grant_found_s;
    logic [SELW-1:0]  grant_idx_s;
    logic             transfer_s;
    logic [WIDTH-1:0] grant_data_s;
    logic [CH-1:0]    in_ready_s;

    // The register can take a new word when it is empty or draining now
    assign load_s = !out_valid_r || out_ready;

    // Round-robin search from ptr+1 upward; CH is a power of two, so the
    // SELW-bit addition wraps from CH-1 to 0 by itself. The last candidate
    // (k = CH) is ptr itself, so a lone valid channel is still served.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        for (int k = 1; k <= CH; k++) begin
            if (!rr_found_s && in_valid[ptr_r + SELW'(k)]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = ptr_r + SELW'(k);
            end else begin
                rr_found_s = rr_found_s;
                rr_idx_s   = rr_idx_s;
            end
        end
    end

    // Choose between the fixed select and the round-robin result
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        case (mode)
            1'b0: begin
                grant_found_s = in_valid[sel];
                grant_idx_s   = sel;
            end
            1'b1: begin
                grant_found_s = rr_found_s;
                grant_idx_s   = rr_idx_s;
            end
            default: begin
                grant_found_s = 1'b0;
                grant_idx_s   = '0;
            end
        endcase
    end

    // A granted channel is valid by construction, so a grant with load is a transfer
    assign transfer_s   = load_s && grant_found_s;
    assign grant_data_s = in_data[grant_idx_s*WIDTH +: WIDTH];

    // Per-channel accept; forced low while reset is asserted
    always_comb begin
        in_ready_s = '0;
        for (int i = 0; i < CH; i++) begin
            if (!rst && transfer_s && (grant_idx_s == SELW'(i))) begin
                in_ready_s[i] = 1'b1;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    assign in_ready = in_ready_s;

    // Output register and round-robin pointer; a load replaces any word that
    // drains on the same edge, giving one word per clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= '0;
            out_ch_r    <= '0;
            out_valid_r <= 1'b0;
            ptr_r       <= SELW'(CH - 1);
        end else if (transfer_s) begin
            out_data_r  <= grant_data_s;
            out_ch_r    <= grant_idx_s;
            out_valid_r <= 1'b1;
            ptr_r       <= grant_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule
